// File: rtl/pixel_unpacker.sv
`default_nettype none
// ============================================================================
// pixel_unpacker : loads R/G/B words in order, emits PPW raster-tagged pixels
// Revision 1.0
// ============================================================================
module pixel_unpacker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           in_data,
  input  logic                  r_rts,
  output logic                  r_rtr,
  input  logic                  g_rts,
  output logic                  g_rtr,
  input  logic                  b_rts,
  output logic                  b_rtr,
  output logic [3*PIX_BITS-1:0] out_pixel,
  output logic                  out_rts,
  input  logic                  out_rtr,
  output logic                  out_sol,
  output logic                  out_sof,
  output logic                  underrun
);

  localparam int PPW   = 32 / PIX_BITS;
  localparam int NIB_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int Y_W   = $clog2(V_ACTIVE);

  typedef enum logic [2:0] {
    LD_R = 3'b001,
    LD_G = 3'b010,
    LD_B = 3'b100
  } ld_state_t;

  ld_state_t        state;
  ld_state_t        state_nxt;
  logic [31:0]      r_buf, g_buf, b_buf;
  logic             front_full;
  logic [31:0]      sh_r, sh_g, sh_b;
  logic             sh_valid;
  logic [NIB_W-1:0] nib_cnt;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             started;

  logic r_xfc, g_xfc, b_xfc, out_xfc, last_nib, load_sh;

  assign r_xfc    = r_rts & r_rtr;
  assign g_xfc    = g_rts & g_rtr;
  assign b_xfc    = b_rts & b_rtr;
  assign out_xfc  = out_rts & out_rtr;
  assign last_nib = (nib_cnt == NIB_W'(PPW - 1));
  // Refill on an empty stage, or in the same edge the last nibble leaves.
  assign load_sh  = front_full & (~sh_valid | (out_xfc & last_nib));

  assign out_rts   = sh_valid;
  assign out_pixel = {sh_r[PIX_BITS-1:0], sh_g[PIX_BITS-1:0], sh_b[PIX_BITS-1:0]};
  assign out_sol   = (x == '0);
  assign out_sof   = (x == '0) & (y == '0);

  always_comb begin
    state_nxt = state;
    r_rtr     = 1'b0;
    g_rtr     = 1'b0;
    b_rtr     = 1'b0;
    case (state)
      LD_R: begin
        r_rtr = ~rst & ~front_full;
        if (r_rts & r_rtr) state_nxt = LD_G;
      end
      LD_G: begin
        g_rtr = ~rst & ~front_full;
        if (g_rts & g_rtr) state_nxt = LD_B;
      end
      LD_B: begin
        b_rtr = ~rst & ~front_full;
        if (b_rts & b_rtr) state_nxt = LD_R;
      end
      default: state_nxt = LD_R;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_R;
      r_buf      <= '0;
      g_buf      <= '0;
      b_buf      <= '0;
      front_full <= 1'b0;
      sh_r       <= '0;
      sh_g       <= '0;
      sh_b       <= '0;
      sh_valid   <= 1'b0;
      nib_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      started    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (r_xfc) r_buf <= in_data;
      if (g_xfc) g_buf <= in_data;
      if (b_xfc) b_buf <= in_data;

      if (load_sh)    front_full <= 1'b0;
      else if (b_xfc) front_full <= 1'b1;

      if (load_sh) begin
        sh_r     <= r_buf;
        sh_g     <= g_buf;
        sh_b     <= b_buf;
        sh_valid <= 1'b1;
        nib_cnt  <= '0;
      end else if (out_xfc) begin
        sh_r    <= sh_r >> PIX_BITS;
        sh_g    <= sh_g >> PIX_BITS;
        sh_b    <= sh_b >> PIX_BITS;
        nib_cnt <= nib_cnt + NIB_W'(1);
        if (last_nib) sh_valid <= 1'b0;
      end

      if (out_xfc) begin
        started <= 1'b1;
        if (x == X_W'(H_ACTIVE - 1)) begin
          x <= '0;
          y <= (y == Y_W'(V_ACTIVE - 1)) ? '0 : y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end

      // Sink asked for a pixel after streaming began and none was offered.
      if (started & out_rtr & ~sh_valid) underrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_unpacker.sv
`default_nettype none
// ============================================================================
// tb_pixel_unpacker : queue-based reference model plus directed/random stimulus
// Revision 1.0
// ============================================================================
module tb_pixel_unpacker;

  localparam int H = 24;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        r_rts, g_rts, b_rts, out_rtr;
  logic        r_rtr, g_rtr, b_rtr, out_rts, out_sol, out_sof, underrun;
  logic [11:0] out_pixel;

  int checks = 0;
  int errors = 0;

  pixel_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .r_rts(r_rts), .r_rtr(r_rtr), .g_rts(g_rts), .g_rtr(g_rtr),
    .b_rts(b_rts), .b_rtr(b_rtr), .out_pixel(out_pixel), .out_rts(out_rts),
    .out_rtr(out_rtr), .out_sol(out_sol), .out_sof(out_sof), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next channel expected, front set, queue of pending pixels.
  bit          m_init = 0;
  int          m_chan, m_x, m_y;
  bit          m_full, m_started, m_under;
  logic [31:0] m_w[3];
  logic [11:0] mq[$];

  always @(posedge clk) begin : model
    bit oxfc, xfer;
    if (rst) begin
      m_init = 1; m_chan = 0; m_full = 0; mq.delete();
      m_x = 0; m_y = 0; m_started = 0; m_under = 0;
    end else if (m_init) begin
      oxfc = (mq.size() != 0) && out_rtr;
      xfer = m_full && (mq.size() == 0 || (oxfc && mq.size() == 1));
      if (m_started && out_rtr && mq.size() == 0) m_under = 1;
      if (oxfc) begin
        void'(mq.pop_front());
        m_started = 1;
        m_x = m_x + 1;
        if (m_x == H) begin
          m_x = 0;
          m_y = (m_y + 1) % V;
        end
      end
      if (xfer) begin
        for (int i = 0; i < 8; i++)
          mq.push_back({m_w[0][4*i +: 4], m_w[1][4*i +: 4], m_w[2][4*i +: 4]});
        m_full = 0;
      end else if (!m_full) begin
        if ((m_chan == 0 && r_rts) || (m_chan == 1 && g_rts) || (m_chan == 2 && b_rts)) begin
          m_w[m_chan] = in_data;
          if (m_chan == 2) m_full = 1;
          m_chan = (m_chan + 1) % 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("r_rtr", r_rtr, (!rst && m_chan == 0 && !m_full));
      chk("g_rtr", g_rtr, (!rst && m_chan == 1 && !m_full));
      chk("b_rtr", b_rtr, (!rst && m_chan == 2 && !m_full));
      chk("out_rts", out_rts, (mq.size() != 0));
      if (mq.size() != 0) chk("out_pixel", out_pixel, mq[0]);
      chk("out_sol", out_sol, (m_x == 0));
      chk("out_sof", out_sof, (m_x == 0 && m_y == 0));
      chk("underrun", underrun, m_under);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_set(input logic [31:0] rw, input logic [31:0] gw, input logic [31:0] bw);
    r_rts = 1; in_data = rw; step();
    r_rts = 0; g_rts = 1; in_data = gw; step();
    g_rts = 0; b_rts = 1; in_data = bw; step();
    b_rts = 0;
  endtask

  task automatic pulse_rst();
    rst = 1; step(); rst = 0;
  endtask

  localparam logic [31:0] RW = 32'h7654_3210;
  localparam logic [31:0] GW = 32'hFEDC_BA98;
  localparam logic [31:0] BW = 32'h0123_4567;

  initial begin
    logic [11:0] lit[8];
    int n, cyc;
    lit = '{12'h087, 12'h196, 12'h2A5, 12'h3B4, 12'h4C3, 12'h5D2, 12'h6E1, 12'h7F0};
    rst = 1; r_rts = 0; g_rts = 0; b_rts = 0; in_data = '0; out_rtr = 0;
    step(); step();
    rst = 0; #1;
    chk("rst_r_rtr", r_rtr, 1);
    chk("rst_g_rtr", g_rtr, 0);
    chk("rst_b_rtr", b_rtr, 0);
    chk("rst_out_rts", out_rts, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_sol", out_sol, 1);
    chk("rst_sof", out_sof, 1);
    chk("rst_underrun", underrun, 0);

    // Out-of-order green request is ignored.
    g_rts = 1; in_data = 32'hDEAD_BEEF; #1;
    chk("order_g_rtr", g_rtr, 0);
    step(); g_rts = 0; #1;
    chk("order_stay_r", r_rtr, 1);

    // Single set: latency and pixel order.
    load_set(RW, GW, BW);
    chk("lat_after_e2", out_rts, 0);
    out_rtr = 1; step();
    chk("lat_after_e3", out_rts, 1);
    for (int i = 0; i < 8; i++) begin
      chk("single_pixel", out_pixel, lit[i]);
      step();
    end
    chk("single_drain", out_rts, 0);
    chk("under_pre", underrun, 0);
    step();
    chk("under_set", underrun, 1);
    step(); step();
    chk("under_hold", underrun, 1);

    // Reset while a set is mid-shift and a partial set is buffered.
    out_rtr = 0; load_set(RW, GW, BW); step();
    out_rtr = 1; step(); step(); step();
    r_rts = 1; in_data = 32'hA5A5_A5A5; step(); r_rts = 0;
    pulse_rst(); #1;
    chk("mid_rst_under", underrun, 0);
    chk("mid_rst_rts", out_rts, 0);
    chk("mid_rst_r_rtr", r_rtr, 1);
    chk("mid_rst_g_rtr", g_rtr, 0);
    chk("mid_rst_sof", out_sof, 1);

    // Back-pressure with a second set filling the front buffer.
    out_rtr = 0;
    load_set(RW, GW, BW);
    for (int i = 0; i < 10 && !out_rts; i++) step();
    chk("bp_valid", out_rts, 1);
    chk("bp_first", out_pixel, 12'h087);
    load_set($urandom, $urandom, $urandom);
    r_rts = 1; g_rts = 1; b_rts = 1;
    for (int k = 0; k < 17; k++) begin
      in_data = $urandom; #1;
      chk("bp_hold_pixel", out_pixel, 12'h087);
      chk("bp_blocked", {r_rtr, g_rtr, b_rtr}, 0);
      chk("bp_underrun", underrun, 0);
      step();
    end
    r_rts = 0; g_rts = 0; b_rts = 0;
    out_rtr = 1;
    for (int i = 0; i < 16; i++) begin
      chk("seam_rts", out_rts, 1);
      step();
    end
    chk("seam_end", out_rts, 0);

    // Raster wrap over one full frame plus two pixels, sources always ready.
    pulse_rst();
    r_rts = 1; g_rts = 1; b_rts = 1; out_rtr = 1;
    n = 0; cyc = 0;
    while (n < H*V + 2 && cyc < 400) begin
      in_data = $urandom;
      if (out_rts) begin
        chk("raster_sol", out_sol, (n % H == 0));
        chk("raster_sof", out_sof, (n % (H*V) == 0));
        n++;
      end
      step(); cyc++;
    end
    if (n < H*V + 2) chk("raster_timeout", n, H*V + 2);
    chk("raster_no_underrun", underrun, 0);

    // Randomized traffic, including illegal requests and occasional resets.
    for (int c = 0; c < 5000; c++) begin
      rst     = ($urandom_range(0, 599) == 0);
      r_rts   = ($urandom_range(0, 3) != 0);
      g_rts   = ($urandom_range(0, 3) != 0);
      b_rts   = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      out_rtr = (c < 2500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
      step();
    end
    rst = 0; r_rts = 0; g_rts = 0; b_rts = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
